carry_chain_add_pipe: RTL and testbench
=======================================

// Module: carry_chain_add_pipe
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor built from MUXCY-rule carry cells.
//  Splits a WIDTH-bit add into SEG_W-bit segments, one register stage per segment, so the carry
//  chain length per cycle is bounded by SEG_W. Used where wide counters, accumulators and
//  comparators exceed single-cycle carry timing. Streams one operation per enabled cycle.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=2)
//  SEG_W  4   bits per pipeline segment (1..WIDTH); NSEG = ceil(WIDTH/SEG_W)
// PORTS
//  C      in   1      clock, all state updates on rising edge
//  CLR_N  in   1      asynchronous active-low reset
//  CE     in   1      clock enable; 0 = whole pipeline holds
//  IN_V   in   1      operands valid this cycle
//  SUB    in   1      1 = A-B, 0 = A+B; travels with its operands
//  A      in   WIDTH  operand A
//  B      in   WIDTH  operand B
//  CI     in   1      carry-in (SUB=0) / borrow-in (SUB=1)
//  O      out  WIDTH  result
//  CO     out  1      carry out of bit WIDTH-1 (SUB=1: 1 = no borrow)
//  OVF    out  1      signed overflow, c[WIDTH] ^ c[WIDTH-1]
//  OUT_V  out  1      O/CO/OVF valid
// BEHAVIOUR
//  - Reset (CLR_N=0, async): every pipeline, skew and deskew register cleared; O=0, CO=0,
//    OVF=0, OUT_V=0 immediately. In-flight operations are dropped; nothing emerges after release.
//  - Operand prep: Bx = SUB ? ~B : B; cin = CI ^ SUB.
//  - Carry cell per bit i (MUXCY rule): S[i]=A[i]^Bx[i]; c[i+1] = S[i] ? c[i] : A[i];
//    sum[i] = S[i] ^ c[i]. c[0] = cin. No other carry logic.
//  - Segment k covers bits [k*SEG_W +: SEG_W]; last segment narrower when WIDTH%SEG_W != 0.
//    Segment k computes on the edge k of the operation (edge 0 = sampling edge); its operands are
//    skewed by k registers, its carry-in is the registered carry-out of segment k-1, and its sum
//    is deskewed by NSEG-1-k registers so all bits of O align.
//  - Latency: result visible after NSEG enabled rising edges counted from and including the
//    sampling edge. Throughput: 1 op per enabled cycle, no stall/backpressure.
//  - OUT_V is IN_V delayed NSEG enabled edges; O/CO/OVF are updated each enabled edge
//    regardless of valid (bubbles carry whatever data was present; consumers qualify with OUT_V).
//  - CE=0: every register holds, including OUT_V; an op held N cycles emerges N cycles late,
//    value unchanged. CE sampled on each edge; no partial advance.
//  - SEG_W >= WIDTH: single segment, latency 1 (registered single-cycle adder).
//  - Wrap-around: O is modulo 2^WIDTH; CO/OVF report the overflow, never saturate.
//  - Simultaneous IN_V with reset release: the edge on which CLR_N is already high samples normally.
// TESTING (WIDTH=16, SEG_W=4 -> latency 4 unless stated)
//  1. A=FFFF B=0001 CI=0 SUB=0 IN_V=1 -> after 4 edges O=0000 CO=1 OVF=0 OUT_V=1 for one cycle.
//  2. A=7FFF B=0001 CI=0 SUB=0 -> O=8000 CO=0 OVF=1; A=0005 B=0007 SUB=1 CI=0 -> O=FFFE CO=0 OVF=0.
//  3. Back-to-back ops 0001+0001, 00FF+0001, 0FFF+0001, FFFF+FFFF on 4 consecutive cycles ->
//     O=0002,0100,1000,FFFE (CO=0,0,0,1) on 4 consecutive cycles, OUT_V high throughout.
//  4. Issue op 1234+1111, CE=0 for 3 cycles after the 2nd edge -> O=2345 appears 7 edges after
//     issue, OUT_V pulses once; no duplicate output.
//  5. Two ops in flight, drive CLR_N=0 mid-cycle -> O=0 CO=0 OVF=0 OUT_V=0 before next edge;
//     after release, OUT_V stays 0 until new IN_V op completes.
//  6. WIDTH=10 SEG_W=4 (NSEG=3): A=3FF B=001 -> O=000 CO=1 after 3 edges; random 10k-op compare
//     against behavioural A+B / A-B model for WIDTH in {8,10,16,33}, SEG_W in {1,3,4,WIDTH}.

Source files
------------

// File: rtl/carry_chain_add_pipe.sv
// Pipelined ripple-carry adder/subtractor built from MUXCY-style carry cells.
// Each SEG_W-bit segment owns one register stage. Operands are skewed into a segment and sums are deskewed out of it.
module carry_chain_add_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ce,
  input  logic             i_in_v,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_ci,
  output logic [WIDTH-1:0] o_o,
  output logic             o_co,
  output logic             o_ovf,
  output logic             o_out_v
);

  localparam int SEGW = (SEG_W >= WIDTH) ? WIDTH : SEG_W;
  localparam int NSEG = (WIDTH + SEGW - 1) / SEGW;

  logic [WIDTH-1:0] w_bx;
  logic             w_cin0;
  logic [NSEG-1:0]  w_segCo;
  logic [NSEG-1:0]  r_v;

  assign w_bx   = i_sub ? ~i_b : i_b;
  assign w_cin0 = i_ci ^ i_sub;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v <= '0;
    end else if (i_ce) begin
      r_v[0] <= i_in_v;
      for (int j = 1; j < NSEG; j++) r_v[j] <= r_v[j-1];
    end
  end

  assign o_out_v = r_v[NSEG-1];
  assign o_co    = w_segCo[NSEG-1];

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int LO = k * SEGW;
    localparam int SW = (LO + SEGW > WIDTH) ? (WIDTH - LO) : SEGW;

    logic [SW-1:0] w_aSeg;
    logic [SW-1:0] w_bxSeg;
    logic [SW-1:0] w_sumSeg;
    logic [SW:0]   w_c;
    logic          w_cin;
    logic          r_cout;
    logic [SW-1:0] r_dsk [NSEG-k];

    if (k == 0) begin : g_first
      assign w_aSeg  = i_a[LO +: SW];
      assign w_bxSeg = w_bx[LO +: SW];
      assign w_cin   = w_cin0;
    end else begin : g_skew
      // Segment k sees its operands k enabled edges after sampling.
      logic [SW-1:0] r_aSk  [k];
      logic [SW-1:0] r_bxSk [k];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int j = 0; j < k; j++) begin
            r_aSk[j]  <= '0;
            r_bxSk[j] <= '0;
          end
        end else if (i_ce) begin
          r_aSk[0]  <= i_a[LO +: SW];
          r_bxSk[0] <= w_bx[LO +: SW];
          for (int j = 1; j < k; j++) begin
            r_aSk[j]  <= r_aSk[j-1];
            r_bxSk[j] <= r_bxSk[j-1];
          end
        end
      end

      assign w_aSeg  = r_aSk[k-1];
      assign w_bxSeg = r_bxSk[k-1];
      assign w_cin   = w_segCo[k-1];
    end

    always_comb begin
      w_c      = '0;
      w_sumSeg = '0;
      w_c[0]   = w_cin;
      for (int i = 0; i < SW; i++) begin
        w_c[i+1]    = (w_aSeg[i] ^ w_bxSeg[i]) ? w_c[i] : w_aSeg[i];
        w_sumSeg[i] = w_aSeg[i] ^ w_bxSeg[i] ^ w_c[i];
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cout <= 1'b0;
        for (int j = 0; j < NSEG - k; j++) r_dsk[j] <= '0;
      end else if (i_ce) begin
        r_cout   <= w_c[SW];
        r_dsk[0] <= w_sumSeg;
        for (int j = 1; j < NSEG - k; j++) r_dsk[j] <= r_dsk[j-1];
      end
    end

    assign w_segCo[k]    = r_cout;
    assign o_o[LO +: SW] = r_dsk[NSEG-1-k];

    if (k == NSEG - 1) begin : g_last
      logic r_ovf;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_ovf <= 1'b0;
        end else if (i_ce) begin
          r_ovf <= w_c[SW] ^ w_c[SW-1];
        end
      end

      assign o_ovf = r_ovf;
    end
  end

endmodule

// File: tb/tb_carry_chain_add_pipe.sv
// Directed bench for carry_chain_add_pipe: 16/4 (latency 4), 10/4 (latency 3) and 8/8 (latency 1) instances.
module tb_carry_chain_add_pipe;

  logic clk = 1'b0;
  logic rstN;
  logic ce;

  logic        inV16, sub16, ci16;
  logic [15:0] a16, b16, o16;
  logic        co16, ovf16, outV16;

  logic        inV10, sub10, ci10;
  logic [9:0]  a10, b10, o10;
  logic        co10, ovf10, outV10;

  logic        inV8, sub8, ci8;
  logic [7:0]  a8, b8, o8;
  logic        co8, ovf8, outV8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  carry_chain_add_pipe #(.WIDTH(16), .SEG_W(4)) dut16 (
    .i_clk(clk), .i_rst_n(rstN), .i_ce(ce), .i_in_v(inV16), .i_sub(sub16),
    .i_a(a16), .i_b(b16), .i_ci(ci16),
    .o_o(o16), .o_co(co16), .o_ovf(ovf16), .o_out_v(outV16)
  );

  carry_chain_add_pipe #(.WIDTH(10), .SEG_W(4)) dut10 (
    .i_clk(clk), .i_rst_n(rstN), .i_ce(ce), .i_in_v(inV10), .i_sub(sub10),
    .i_a(a10), .i_b(b10), .i_ci(ci10),
    .o_o(o10), .o_co(co10), .o_ovf(ovf10), .o_out_v(outV10)
  );

  carry_chain_add_pipe #(.WIDTH(8), .SEG_W(8)) dut8 (
    .i_clk(clk), .i_rst_n(rstN), .i_ce(ce), .i_in_v(inV8), .i_sub(sub8),
    .i_a(a8), .i_b(b8), .i_ci(ci8),
    .o_o(o8), .o_co(co8), .o_ovf(ovf8), .o_out_v(outV8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check16(input string tag, input logic [15:0] o, input logic co, input logic ovf, input logic v);
    checkOutput({tag, ".O"}, 64'(o16), 64'(o));
    checkOutput({tag, ".CO"}, 64'(co16), 64'(co));
    checkOutput({tag, ".OVF"}, 64'(ovf16), 64'(ovf));
    checkOutput({tag, ".OUT_V"}, 64'(outV16), 64'(v));
  endtask

  // Drive one op into the 16-bit instance for exactly one sampling edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic ci);
    a16   = a;
    b16   = b;
    sub16 = sub;
    ci16  = ci;
    inV16 = 1'b1;
    tick();
    inV16 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    rstN  = 1'b0;
    ce    = 1'b1;
    inV16 = 1'b0; sub16 = 1'b0; ci16 = 1'b0; a16 = '0; b16 = '0;
    inV10 = 1'b0; sub10 = 1'b0; ci10 = 1'b0; a10 = '0; b10 = '0;
    inV8  = 1'b0; sub8  = 1'b0; ci8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) tick();
    check16("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.OUT_V10", 64'(outV10), 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    // FFFF + 0001 wraps to zero with carry out.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick(); tick();
    checkOutput("wrap.early", 64'(outV16), 64'd0);
    tick();
    check16("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("wrap.pulse", 64'(outV16), 64'd0);

    // Signed overflow, subtraction with borrow, borrow-in.
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0);
    applyStimulus(16'h0005, 16'h0003, 1'b1, 1'b1);
    tick();
    check16("ovf", 16'h8000, 1'b0, 1'b1, 1'b1);
    tick();
    check16("sub", 16'hFFFE, 1'b0, 1'b0, 1'b1);
    tick();
    check16("subBorrowIn", 16'h0001, 1'b1, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("sub.idle", 64'(outV16), 64'd0);

    // Back-to-back stream, carries rippling across 1, 2 and 3 segments.
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    check16("b2b0", 16'h0002, 1'b0, 1'b0, 1'b1);
    tick();
    check16("b2b1", 16'h0100, 1'b0, 1'b0, 1'b1);
    tick();
    check16("b2b2", 16'h1000, 1'b0, 1'b0, 1'b1);
    tick();
    check16("b2b3", 16'hFFFE, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("b2b.end", 64'(outV16), 64'd0);
    repeat (3) tick();

    // Clock-enable stall: op held 3 cycles emerges 3 edges late, once.
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
    tick();
    ce = 1'b0;
    repeat (3) tick();
    checkOutput("stall.hold", 64'(outV16), 64'd0);
    ce = 1'b1;
    tick();
    checkOutput("stall.early", 64'(outV16), 64'd0);
    tick();
    check16("stall", 16'h2345, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("stall.nodup", 64'(outV16), 64'd0);
    repeat (3) tick();

    // Asynchronous reset mid-cycle with ops in flight.
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
    applyStimulus(16'h0003, 16'h0003, 1'b0, 1'b0);
    tick();
    check16("preRst", 16'h0002, 1'b0, 1'b0, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    check16("asyncRst", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("postRst%0d", i), 64'(outV16), 64'd0);
    end
    applyStimulus(16'h0003, 16'h0004, 1'b0, 1'b0);
    repeat (3) tick();
    check16("afterRst", 16'h0007, 1'b0, 1'b0, 1'b1);

    // 10-bit instance, three segments with a narrow top segment.
    a10 = 10'h3FF; b10 = 10'h001; sub10 = 1'b0; ci10 = 1'b0; inV10 = 1'b1;
    tick();
    a10 = 10'h000; b10 = 10'h001; sub10 = 1'b1;
    tick();
    a10 = 10'h200; b10 = 10'h001; sub10 = 1'b1;
    checkOutput("w10.early", 64'(outV10), 64'd0);
    tick();
    inV10 = 1'b0;
    checkOutput("w10.wrap.O", 64'(o10), 64'h000);
    checkOutput("w10.wrap.CO", 64'(co10), 64'd1);
    checkOutput("w10.wrap.OVF", 64'(ovf10), 64'd0);
    checkOutput("w10.wrap.OUT_V", 64'(outV10), 64'd1);
    tick();
    checkOutput("w10.neg.O", 64'(o10), 64'h3FF);
    checkOutput("w10.neg.CO", 64'(co10), 64'd0);
    checkOutput("w10.neg.OVF", 64'(ovf10), 64'd0);
    tick();
    checkOutput("w10.ovf.O", 64'(o10), 64'h1FF);
    checkOutput("w10.ovf.CO", 64'(co10), 64'd1);
    checkOutput("w10.ovf.OVF", 64'(ovf10), 64'd1);
    tick();
    checkOutput("w10.end", 64'(outV10), 64'd0);

    // Single-segment instance: latency 1.
    a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; ci8 = 1'b0; inV8 = 1'b1;
    tick();
    inV8 = 1'b0;
    checkOutput("w8.O", 64'(o8), 64'h80);
    checkOutput("w8.CO", 64'(co8), 64'd0);
    checkOutput("w8.OVF", 64'(ovf8), 64'd1);
    checkOutput("w8.OUT_V", 64'(outV8), 64'd1);
    tick();
    checkOutput("w8.end", 64'(outV8), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
